sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
Sequences all accesses to the external SRAM bus (M1CSn/MRDn/MWRn, MAH/MAL, MD) and shares it between two requesters: the CPU access path (highest priority) and a secondary DMA/ICD port.
Generates setup/strobe/hold timing in clk6x cycles, captures read data and returns it with a completion pulse.
Sits between the CPU bus decoder and the memory pads in NORA.

Parameters:
AW, 21, memory address width (MAH+MAL)
T_SETUP, 1, cycles CS low with address/data valid before strobe (>=1)
T_STROBE, 2, cycles MRDn/MWRn held low (>=1)
T_HOLD, 1, cycles CS low after strobe release (>=1)

Ports:
clk6x  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  one-cycle pulse: CPU SRAM access request
cpu_wr  in  1  CPU access is write (qualified by cpu_req)
cpu_addr  in  AW  CPU physical address (qualified by cpu_req)
cpu_wdata  in  8  CPU write data (qualified by cpu_req)
cpu_rdata  out  8  last CPU read data
cpu_done  out  1  one-cycle pulse: CPU access finished
cpu_overrun  out  1  sticky: CPU request lost
cpu_window  in  1  high = CPU access may start soon; blocks new DMA grants
dma_req  in  1  level request, held with stable dma_wr/addr/wdata until dma_ack
dma_wr  in  1  DMA access is write
dma_addr  in  AW  DMA address
dma_wdata  in  8  DMA write data
dma_rdata  out  8  last DMA read data
dma_ack  out  1  one-cycle pulse: DMA access finished
mem_addr  out  AW  SRAM address
mem_wdata  out  8  SRAM write data
mem_wdata_oe  out  1  MD output enable
mem_rdata  in  8  SRAM read data
m1cs_n  out  1  SRAM chip-select, active-low
mrd_n  out  1  read strobe, active-low
mwr_n  out  1  write strobe, active-low
busy  out  1  access in progress (state != IDLE)

Behaviour:
- All outputs registered. Reset values: m1cs_n=1, mrd_n=1, mwr_n=1, mem_wdata_oe=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dma_rdata=0, cpu_done=0, dma_ack=0, cpu_overrun=0, busy=0. FSM=IDLE, CPU pending flag cleared.
- FSM states: IDLE -> SETUP (T_SETUP cycles) -> STROBE (T_STROBE cycles) -> HOLD (T_HOLD cycles) -> IDLE. A single down-counter times each state.
- Grant (IDLE only, evaluated each edge):
  - CPU source: cpu_req or CPU pending flag.
  - DMA is granted only if dma_req=1, no CPU source, cpu_window=0, and dma_ack is not high this cycle. The last condition blocks double-servicing a request still held in the ack cycle.
  - CPU wins when CPU and DMA request simultaneously.
- On grant: latch owner, wr, addr, and wdata into mem_addr/mem_wdata. Enter SETUP with m1cs_n=0. mem_wdata_oe=1 for writes, held through SETUP, STROBE and HOLD.
- STROBE: mrd_n=0 (read) or mwr_n=0 (write). mem_rdata is captured on the edge ending the last STROBE cycle into cpu_rdata or dma_rdata by owner. The other rdata register is unchanged.
- HOLD: strobes high; m1cs_n=0; address and wdata stable.
- Completion: the first IDLE cycle after HOLD has m1cs_n=1 and mem_wdata_oe=0, plus a cpu_done or dma_ack pulse by owner. A new grant may occur in that same cycle (back-to-back).
- Latency with defaults: request sampled at edge E0 -> SETUP cycle 1, STROBE 2-3, HOLD 4, done/ack in cycle 5. In general, done/ack comes 1+T_SETUP+T_STROBE+T_HOLD cycles after the request edge.
- cpu_req while busy sets the one-deep pending flag (latches wr/addr/wdata). It is served at the next IDLE with priority. A cpu_req while the pending flag is already set sets cpu_overrun (sticky until rst); the new request is dropped and the pending one is kept.
- DMA in progress is never aborted by CPU; the CPU waits via the pending flag. cpu_window only gates new DMA grants.
- rst mid-access: immediate strobe/CS release, pending cleared, no done/ack generated.

Test Plan:
- CPU write 0x000010<-0x12, then read 0x000010 -> m1cs_n low 4 cycles, mwr_n low cycles 2-3, cpu_done at cycle 5; read returns cpu_rdata=0x12.
- cpu_req and dma_req in same cycle (DMA write 0x000020<-0x55) -> CPU served first. DMA is granted in the CPU done cycle and acked 5 cycles later. SRAM 0x20 holds 0x55.
- dma_req held with cpu_window=1 for 10 cycles -> no grant, m1cs_n stays 1. cpu_window drops -> grant next edge, dma_ack 5 cycles later, exactly one access.
- cpu_req during DMA STROBE -> CPU access starts in the dma_ack cycle, cpu_done 5 cycles later. Second cpu_req while pending -> cpu_overrun=1, only the first CPU access is performed.
- Parameters T_SETUP=2, T_STROBE=3, T_HOLD=2, read 0x1FFFFF -> mrd_n low exactly 3 cycles, done 8 cycles after request, mem_addr=0x1FFFFF.
- Assert rst during STROBE of a write -> m1cs_n/mwr_n go high without waiting for a clock edge, no cpu_done, busy=0, pending cleared.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// External SRAM bus sequencer shared by the CPU path (priority, one-deep pending slot) and a DMA port.
// Each access runs SETUP/STROBE/HOLD timed by one down-counter, then a cpu_done or dma_ack pulse.
module sram_bus_arbiter #(
  parameter int AW       = 21,
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic          clk6x,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_overrun,
  input  logic          cpu_window,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic [7:0]    dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wdata_oe,
  input  logic [7:0]    mem_rdata,
  output logic          m1cs_n,
  output logic          mrd_n,
  output logic          mwr_n,
  output logic          busy
);

  localparam int CW = $clog2(T_SETUP + T_STROBE + T_HOLD + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          owner_cpu, owner_cpu_nx;
  logic          acc_wr, acc_wr_nx;
  logic          pend, pend_nx;
  logic          pend_wr, pend_wr_nx;
  logic [AW-1:0] pend_addr, pend_addr_nx;
  logic [7:0]    pend_wdata, pend_wdata_nx;
  logic          start;

  logic [AW-1:0] mem_addr_nx;
  logic [7:0]    mem_wdata_nx, cpu_rdata_nx, dma_rdata_nx;
  logic          oe_nx, cs_nx, rd_nx, wr_nx, done_nx, ack_nx, ovr_nx, busy_nx;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    owner_cpu_nx  = owner_cpu;
    acc_wr_nx     = acc_wr;
    pend_nx       = pend;
    pend_wr_nx    = pend_wr;
    pend_addr_nx  = pend_addr;
    pend_wdata_nx = pend_wdata;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    cpu_rdata_nx  = cpu_rdata;
    dma_rdata_nx  = dma_rdata;
    oe_nx         = mem_wdata_oe;
    cs_nx         = m1cs_n;
    rd_nx         = mrd_n;
    wr_nx         = mwr_n;
    done_nx       = 1'b0;
    ack_nx        = 1'b0;
    ovr_nx        = cpu_overrun;
    start         = 1'b0;

    // CPU requests arriving mid-access park in the pending slot; a second one is lost.
    if (state != IDLE && cpu_req) begin
      if (pend) begin
        ovr_nx = 1'b1;
      end else begin
        pend_nx       = 1'b1;
        pend_wr_nx    = cpu_wr;
        pend_addr_nx  = cpu_addr;
        pend_wdata_nx = cpu_wdata;
      end
    end

    case (state)
      IDLE: begin
        if (pend || cpu_req) begin
          start        = 1'b1;
          owner_cpu_nx = 1'b1;
          if (pend) begin
            acc_wr_nx    = pend_wr;
            mem_addr_nx  = pend_addr;
            mem_wdata_nx = pend_wdata;
            pend_nx      = 1'b0;
            if (cpu_req) ovr_nx = 1'b1;
          end else begin
            acc_wr_nx    = cpu_wr;
            mem_addr_nx  = cpu_addr;
            mem_wdata_nx = cpu_wdata;
          end
        end else if (dma_req && !cpu_window && !dma_ack) begin
          // dma_ack high means this dma_req may be the one just serviced.
          start        = 1'b1;
          owner_cpu_nx = 1'b0;
          acc_wr_nx    = dma_wr;
          mem_addr_nx  = dma_addr;
          mem_wdata_nx = dma_wdata;
        end
        if (start) begin
          state_nx = SETUP;
          cnt_nx   = CW'(T_SETUP - 1);
          cs_nx    = 1'b0;
          oe_nx    = acc_wr_nx;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = CW'(T_STROBE - 1);
          rd_nx    = acc_wr;
          wr_nx    = ~acc_wr;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (owner_cpu) cpu_rdata_nx = mem_rdata;
          else           dma_rdata_nx = mem_rdata;
          state_nx = HOLD;
          cnt_nx   = CW'(T_HOLD - 1);
          rd_nx    = 1'b1;
          wr_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          cs_nx    = 1'b1;
          oe_nx    = 1'b0;
          done_nx  = owner_cpu;
          ack_nx   = ~owner_cpu;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      owner_cpu    <= 1'b0;
      acc_wr       <= 1'b0;
      pend         <= 1'b0;
      pend_wr      <= 1'b0;
      pend_addr    <= '0;
      pend_wdata   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      mem_wdata_oe <= 1'b0;
      m1cs_n       <= 1'b1;
      mrd_n        <= 1'b1;
      mwr_n        <= 1'b1;
      cpu_done     <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_overrun  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      owner_cpu    <= owner_cpu_nx;
      acc_wr       <= acc_wr_nx;
      pend         <= pend_nx;
      pend_wr      <= pend_wr_nx;
      pend_addr    <= pend_addr_nx;
      pend_wdata   <= pend_wdata_nx;
      mem_addr     <= mem_addr_nx;
      mem_wdata    <= mem_wdata_nx;
      cpu_rdata    <= cpu_rdata_nx;
      dma_rdata    <= dma_rdata_nx;
      mem_wdata_oe <= oe_nx;
      m1cs_n       <= cs_nx;
      mrd_n        <= rd_nx;
      mwr_n        <= wr_nx;
      cpu_done     <= done_nx;
      dma_ack      <= ack_nx;
      cpu_overrun  <= ovr_nx;
      busy         <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: default-timing instance with a small SRAM model, plus a stretched-timing instance.
module tb_sram_bus_arbiter;

  logic        clk6x = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, cpu_window, dma_req, dma_wr;
  logic [20:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_overrun, dma_ack, mem_wdata_oe, m1cs_n, mrd_n, mwr_n, busy;

  logic        cpu_req2, cpu_wr2, zero1;
  logic [20:0] cpu_addr2, zaddr, mem_addr2;
  logic [7:0]  zbyte, cpu_rdata2, dma_rdata2, mem_wdata2, mem_rdata2;
  logic        cpu_done2, cpu_overrun2, dma_ack2, mem_wdata_oe2, m1cs_n2, mrd_n2, mwr_n2, busy2;

  int total = 0;
  int bad   = 0;

  always #5 clk6x = ~clk6x;

  sram_bus_arbiter dut (
    .clk6x(clk6x), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_overrun(cpu_overrun), .cpu_window(cpu_window),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata),
    .m1cs_n(m1cs_n), .mrd_n(mrd_n), .mwr_n(mwr_n), .busy(busy)
  );

  sram_bus_arbiter #(.AW(21), .T_SETUP(2), .T_STROBE(3), .T_HOLD(2)) dut2 (
    .clk6x(clk6x), .rst(rst),
    .cpu_req(cpu_req2), .cpu_wr(cpu_wr2), .cpu_addr(cpu_addr2), .cpu_wdata(zbyte),
    .cpu_rdata(cpu_rdata2), .cpu_done(cpu_done2), .cpu_overrun(cpu_overrun2), .cpu_window(zero1),
    .dma_req(zero1), .dma_wr(zero1), .dma_addr(zaddr), .dma_wdata(zbyte),
    .dma_rdata(dma_rdata2), .dma_ack(dma_ack2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wdata_oe(mem_wdata_oe2), .mem_rdata(mem_rdata2),
    .m1cs_n(m1cs_n2), .mrd_n(mrd_n2), .mwr_n(mwr_n2), .busy(busy2)
  );

  // SRAM model: low address byte selects one of 256 cells.
  logic [7:0] sram [256];
  assign mem_rdata  = (!m1cs_n && !mrd_n) ? sram[mem_addr[7:0]] : 8'h00;
  assign mem_rdata2 = (!m1cs_n2 && !mrd_n2) ? 8'h5A : 8'h00;
  always @(posedge clk6x)
    if (!m1cs_n && !mwr_n && mem_wdata_oe) sram[mem_addr[7:0]] <= mem_wdata;

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp = {m1cs_n, mrd_n, mwr_n, mem_wdata_oe, cpu_done, busy} sampled after the edge
  typedef struct {
    logic        req;
    logic        wr;
    logic [20:0] addr;
    logic [7:0]  wd;
    logic [5:0]  exp;
  } vec_t;
  vec_t tbl [10];

  int done_cyc, ack_cyc, n_ack, n_done, n_acc, cs_low, rd_low;
  logic prev_cs;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 8'h00;
    rst = 1'b1; cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_window = 0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
    cpu_req2 = 0; cpu_wr2 = 0; cpu_addr2 = '0; zero1 = 0; zaddr = '0; zbyte = '0;

    tbl[0] = '{1'b1, 1'b1, 21'h10, 8'h12, 6'b011101};
    tbl[1] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b010101};
    tbl[2] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b010101};
    tbl[3] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b011101};
    tbl[4] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b111010};
    tbl[5] = '{1'b1, 1'b0, 21'h10, 8'h00, 6'b011001};
    tbl[6] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b001001};
    tbl[7] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b001001};
    tbl[8] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b011001};
    tbl[9] = '{1'b0, 1'b0, 21'h00, 8'h00, 6'b111010};

    // reset state
    tick(); tick();
    chk("rst_ctrl", {24'd0, m1cs_n, mrd_n, mwr_n, mem_wdata_oe, cpu_done, dma_ack, cpu_overrun, busy}, 32'hE0);
    chk("rst_addr", {11'd0, mem_addr}, 32'h0);
    chk("rst_data", {8'd0, mem_wdata, cpu_rdata, dma_rdata}, 32'h0);
    rst = 1'b0;

    // CPU write 0x10<-0x12 then back-to-back read
    for (int i = 0; i < 10; i++) begin
      cpu_req = tbl[i].req; cpu_wr = tbl[i].wr; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wd;
      tick();
      chk($sformatf("vec%0d", i), {26'd0, m1cs_n, mrd_n, mwr_n, mem_wdata_oe, cpu_done, busy}, {26'd0, tbl[i].exp});
    end
    cpu_req = 0;
    chk("cpu_rd_data", {24'd0, cpu_rdata}, 32'h12);

    // simultaneous CPU and DMA: CPU first, DMA granted in CPU done cycle
    cpu_req = 1; cpu_wr = 1; cpu_addr = 21'h30; cpu_wdata = 8'h77;
    dma_req = 1; dma_wr = 1; dma_addr = 21'h20; dma_wdata = 8'h55;
    done_cyc = 0; ack_cyc = 0; n_ack = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      cpu_req = 0;
      if (cpu_done && done_cyc == 0) done_cyc = k;
      if (dma_ack) begin n_ack++; if (ack_cyc == 0) ack_cyc = k; dma_req = 0; end
    end
    chk("prio_done_cyc", done_cyc, 5);
    chk("prio_ack_cyc", ack_cyc, 10);
    chk("prio_n_ack", n_ack, 1);
    chk("prio_sram20", {24'd0, sram[8'h20]}, 32'h55);
    chk("prio_sram30", {24'd0, sram[8'h30]}, 32'h77);

    // cpu_window blocks DMA; dma_req held through the ack cycle must not restart
    cpu_window = 1; dma_req = 1; dma_wr = 0; dma_addr = 21'h20;
    cs_low = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (!m1cs_n) cs_low++;
    end
    chk("window_cs_low", cs_low, 0);
    cpu_window = 0; ack_cyc = 0; n_ack = 0; n_acc = 0; prev_cs = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) chk("window_grant", {31'd0, m1cs_n}, 0);
      if (prev_cs && !m1cs_n) n_acc++;
      prev_cs = m1cs_n;
      if (dma_ack) begin n_ack++; if (ack_cyc == 0) ack_cyc = k; end
      if (ack_cyc != 0 && k == ack_cyc + 1) dma_req = 0;
    end
    dma_req = 0;
    chk("window_ack_cyc", ack_cyc, 5);
    chk("window_n_acc", n_acc, 1);
    chk("window_n_ack", n_ack, 1);
    chk("window_rdata", {24'd0, dma_rdata}, 32'h55);

    // CPU during DMA strobe goes pending; second CPU request overruns
    dma_req = 1; dma_wr = 1; dma_addr = 21'h40; dma_wdata = 8'h99;
    ack_cyc = 0; done_cyc = 0; n_done = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      cpu_req = 0;
      if (k == 2) begin cpu_req = 1; cpu_wr = 1; cpu_addr = 21'h50; cpu_wdata = 8'h11; end
      if (k == 3) begin cpu_req = 1; cpu_wr = 1; cpu_addr = 21'h60; cpu_wdata = 8'h22; end
      if (k == 6) chk("pend_start", {m1cs_n, 10'd0, mem_addr}, {11'd0, 21'h50});
      if (dma_ack && ack_cyc == 0) begin ack_cyc = k; dma_req = 0; end
      if (cpu_done) begin n_done++; if (done_cyc == 0) done_cyc = k; end
    end
    chk("pend_ack_cyc", ack_cyc, 5);
    chk("pend_done_cyc", done_cyc, 10);
    chk("pend_n_done", n_done, 1);
    chk("pend_overrun", {31'd0, cpu_overrun}, 1);
    chk("pend_sram", {8'd0, sram[8'h40], sram[8'h50], sram[8'h60]}, 32'h991100);

    // stretched timing instance: read 0x1FFFFF
    cpu_req2 = 1; cpu_wr2 = 0; cpu_addr2 = 21'h1FFFFF;
    done_cyc = 0; rd_low = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      cpu_req2 = 0;
      if (k == 1) chk("t2_addr", {11'd0, mem_addr2}, 32'h1FFFFF);
      if (!mrd_n2) rd_low++;
      if (cpu_done2 && done_cyc == 0) done_cyc = k;
    end
    chk("t2_rd_low", rd_low, 3);
    chk("t2_done_cyc", done_cyc, 8);
    chk("t2_rdata", {24'd0, cpu_rdata2}, 32'h5A);

    // reset in the middle of a write strobe, with a CPU request pending
    cpu_req = 1; cpu_wr = 1; cpu_addr = 21'h70; cpu_wdata = 8'h33;
    tick();
    cpu_req = 0;
    tick();
    cpu_req = 1; cpu_addr = 21'h74; cpu_wdata = 8'h44;
    tick();
    cpu_req = 0;
    chk("mid_strobe", {30'd0, m1cs_n, mwr_n}, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {28'd0, m1cs_n, mwr_n, busy, mem_wdata_oe}, 32'hC);
    tick(); tick();
    rst = 1'b0;
    n_done = 0; cs_low = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (cpu_done) n_done++;
      if (!m1cs_n) cs_low++;
    end
    chk("rst_no_done", n_done, 0);
    chk("rst_pend_clr", cs_low, 0);
    chk("rst_ovr_clr", {31'd0, cpu_overrun}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
